// File: rtl/alu4_pkg.sv
// alu4_pkg: opcodes, instruction kinds, instruction layout and controller states shared by the alu4 slice.
package alu4_pkg;
    localparam logic [2:0] OP_NOTA = 3'd0;
    localparam logic [2:0] OP_NOTB = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_ADD  = 3'd6;
    localparam logic [2:0] OP_SUB  = 3'd7;
    localparam logic KIND_ALU  = 1'b0;
    localparam logic KIND_LOAD = 1'b1;
    // Field order fixes bit positions: kind[9] op[8:6] rd[5:4] rs1[3:2] rs2[1:0]
    typedef struct packed {
        logic       kind;
        logic [2:0] op;
        logic [1:0] rd;
        logic [1:0] rs1;
        logic [1:0] rs2;
    } instr_t;
    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_WB} state_t;
endpackage

// File: rtl/alu4.sv
// alu4: 4-bit combinational ALU with {c,n,z,v} flags; c and v are only set by add/subtract.
module alu4
    import alu4_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] op,
    output logic [3:0] y,
    output logic       c,
    output logic       n,
    output logic       z,
    output logic       v
);
    logic [3:0] bx;
    logic [4:0] sum;
    logic       arith;
    always_comb begin
        bx    = op == OP_SUB ? ~b : b;
        sum   = {1'b0, a} + {1'b0, bx} + {4'b0, op == OP_SUB};
        arith = op == OP_ADD || op == OP_SUB;
        case (op)
            OP_NOTA: y = ~a;
            OP_NOTB: y = ~b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            default: y = sum[3:0];
        endcase
        c = arith && sum[4];
        n = y[3];
        z = y == 4'h0;
        v = arith && (a[3] == bx[3]) && (y[3] != a[3]);
    end
endmodule

// File: rtl/alu4_regfile.sv
// alu4_regfile: 4x4-bit register file, two operand read ports, one debug read port, one synchronous write port.
module alu4_regfile #(
    parameter int         NUM_REGS = 4,
    parameter logic [3:0] REG_INIT = 4'h0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       we,
    input  logic [1:0] wa,
    input  logic [3:0] wd,
    input  logic [1:0] ra1,
    output logic [3:0] rdata1,
    input  logic [1:0] ra2,
    output logic [3:0] rdata2,
    input  logic [1:0] dbg_addr,
    output logic [3:0] dbg_data
);
    logic [3:0] regs [NUM_REGS];
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= REG_INIT;
        end else if (we) begin
            regs[wa] <= wd;
        end
    end
    assign rdata1   = regs[ra1];
    assign rdata2   = regs[ra2];
    assign dbg_data = regs[dbg_addr];
endmodule

// File: rtl/alu4_ctrl.sv
// alu4_ctrl: IDLE->EXEC->WB sequencer around alu4 and a 4x4 register file.
// Define ALU4_CTRL_OVERLAP_EN to accept the next instruction during WB (1 instr / 2 cycles).
module alu4_ctrl
    import alu4_pkg::*;
#(
    parameter int         NUM_REGS = 4,
    parameter logic [3:0] REG_INIT = 4'h0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [9:0] in_instr,
    output logic       out_valid,
    output logic [3:0] out_result,
    output logic [3:0] out_flags,
    input  logic [1:0] dbg_addr,
    output logic [3:0] dbg_data
);
    state_t     state, state_nx;
    instr_t     instr_q;
    logic [3:0] res_q, flg_q, rdata1, rdata2, y, res_nx;
    logic       c, n, z, v, xfer;
`ifdef ALU4_CTRL_OVERLAP_EN
    assign in_ready = state == ST_IDLE || state == ST_WB;
`else
    assign in_ready = state == ST_IDLE;
`endif
    assign xfer       = in_valid && in_ready;
    assign out_valid  = state == ST_WB;
    // The holding register doubles as the result output, so it is valid during the WB pulse
    assign out_result = res_q;
    always_comb begin
        state_nx = state == ST_EXEC ? ST_WB : (xfer ? ST_EXEC : ST_IDLE);
        res_nx   = instr_q.kind == KIND_LOAD ? {instr_q.rs1, instr_q.rs2} : y;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            instr_q   <= '0;
            res_q     <= '0;
            flg_q     <= '0;
            out_flags <= '0;
        end else begin
            state <= state_nx;
            if (xfer) instr_q <= instr_t'(in_instr);
            if (state == ST_EXEC) begin
                res_q <= res_nx;
                flg_q <= {c, n, z, v};
            end
            if (state == ST_WB && instr_q.kind == KIND_ALU) out_flags <= flg_q;
        end
    end
    alu4_regfile #(.NUM_REGS(NUM_REGS), .REG_INIT(REG_INIT)) u_regfile (
        .clk      (clk),
        .reset_n  (reset_n),
        .we       (out_valid),
        .wa       (instr_q.rd),
        .wd       (res_q),
        .ra1      (instr_q.rs1),
        .rdata1   (rdata1),
        .ra2      (instr_q.rs2),
        .rdata2   (rdata2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );
    alu4 u_alu (
        .a  (rdata1),
        .b  (rdata2),
        .op (instr_q.op),
        .y  (y),
        .c  (c),
        .n  (n),
        .z  (z),
        .v  (v)
    );
endmodule

// File: tb/tb_alu4_ctrl.sv
// tb_alu4_ctrl: directed self-checking bench for alu4_ctrl with hand-computed results and flags.
module tb_alu4_ctrl;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [9:0] in_instr = '0;
    logic       out_valid;
    logic [3:0] out_result;
    logic [3:0] out_flags;
    logic [1:0] dbg_addr = '0;
    logic [3:0] dbg_data;
    int n_cmp = 0;
    int n_bad = 0;
`ifdef ALU4_CTRL_OVERLAP_EN
    localparam int GAP = 2, PULSES = 7, READY_CNT = 7;
`else
    localparam int GAP = 3, PULSES = 5, READY_CNT = 4;
`endif

    alu4_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .out_valid  (out_valid),
        .out_result (out_result),
        .out_flags  (out_flags),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] mk(input logic k, input logic [2:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs1, input logic [1:0] rs2);
        return {k, op, rd, rs1, rs2};
    endfunction

    // Issue one instruction, check the result during the out_valid pulse, then flags and rd afterwards
    task automatic run(input string tag, input logic [9:0] ins, input logic [3:0] er, input logic [3:0] ef);
        int n;
        n = 0;
        while (!in_ready && n < 10) begin @(negedge clk); n++; end
        dbg_addr = ins[5:4];
        in_valid = 1'b1;
        in_instr = ins;
        @(negedge clk);
        in_valid = 1'b0;
        in_instr = 10'($urandom);
        n = 0;
        while (!out_valid && n < 10) begin @(negedge clk); n++; end
        chk({tag, " valid"}, out_valid, 1);
        chk({tag, " result"}, out_result, er);
        @(negedge clk);
        chk({tag, " pulse"}, out_valid, 0);
        chk({tag, " flags"}, out_flags, ef);
        chk({tag, " rd"}, dbg_data, er);
    endtask

    initial begin
        int last, pulses, rdy;
        repeat (3) @(negedge clk);
        chk("rst valid", out_valid, 0);
        chk("rst flags", out_flags, 0);
        chk("rst result", out_result, 0);
        chk("rst ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1 chk("rst reg", dbg_data, 0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        run("ld r0=7", mk(1, 0, 0, 1, 3), 4'h7, 4'h0);
        run("ld r1=1", mk(1, 0, 1, 0, 1), 4'h1, 4'h0);
        run("add 7+1", mk(0, 6, 2, 0, 1), 4'h8, 4'b0101);
        run("ld r3=3", mk(1, 0, 3, 0, 3), 4'h3, 4'b0101);
        run("sub r3-r3", mk(0, 7, 3, 3, 3), 4'h0, 4'b1010);
        run("ld r0=a", mk(1, 0, 0, 2, 2), 4'hA, 4'b1010);
        run("ld r1=c", mk(1, 0, 1, 3, 0), 4'hC, 4'b1010);
        run("and", mk(0, 2, 2, 0, 1), 4'h8, 4'b0100);
        run("or", mk(0, 3, 2, 0, 1), 4'hE, 4'b0100);
        run("xor", mk(0, 4, 2, 0, 1), 4'h6, 4'b0000);
        run("nota", mk(0, 0, 2, 0, 1), 4'h5, 4'b0000);
        run("notb", mk(0, 1, 2, 0, 1), 4'h3, 4'b0000);
        run("xnor", mk(0, 5, 2, 0, 1), 4'h9, 4'b0100);
        run("ld r3=f", mk(1, 0, 3, 3, 3), 4'hF, 4'b0100);
        run("add a+c", mk(0, 6, 2, 0, 1), 4'h6, 4'b1001);
        run("sub c-a", mk(0, 7, 2, 1, 0), 4'h2, 4'b1000);
        // Back-to-back offers with in_valid held high
        last = -1; pulses = 0; rdy = 0;
        in_valid = 1'b1;
        in_instr = mk(1, 0, 3, 1, 1);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (out_valid) begin
                if (last >= 0) chk("gap", i - last, GAP);
                pulses++;
                last = i;
            end
            if (in_ready) rdy++;
        end
        in_valid = 1'b0;
        chk("pulses", pulses, PULSES);
        chk("ready cnt", rdy, READY_CNT);
        @(negedge clk);
        dbg_addr = 2'd3;
        #1 chk("stream rd", dbg_data, 4'h5);
        // Reset while an instruction is in EXEC
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = mk(0, 6, 2, 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort valid", out_valid, 0);
        end
        chk("abort flags", out_flags, 0);
        chk("abort ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1 chk("abort reg", dbg_data, 0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        chk("post ready", in_ready, 1);
        run("post ld", mk(1, 0, 1, 1, 2), 4'h6, 4'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
